// File: rtl/lms_coeff_update.sv
// Serial sign-exact LMS coefficient updater: one tap per cycle into a working set,
// published atomically to the FIR through a shadow register on commit.
module lms_coeff_update #(
    parameter int NTAPS      = 16,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 32,
    parameter int MU_SHIFT   = 12,
    parameter bit INIT_UNITY = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] signal_in,
    input  logic signed [DATA_W-1:0] err_in,
    input  logic                     freeze,
    input  logic                     clear_coeffs,
    output logic                     busy,
    output logic                     update_done,
    output logic                     sample_dropped,
    output logic [NTAPS*COEF_W-1:0]  coeffs_out
);
    localparam int IDX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;
    state_t state, state_next;

    logic signed [DATA_W-1:0] x_line   [NTAPS];
    logic signed [COEF_W-1:0] w_work   [NTAPS];
    logic signed [COEF_W-1:0] w_shadow [NTAPS];
    logic signed [DATA_W-1:0] err_q;
    logic        [IDX_W-1:0]  idx;

    logic                     accept;
    logic                     last_tap;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_shift;
    logic signed [COEF_W:0]   delta;
    logic signed [COEF_W:0]   sum;
    logic signed [COEF_W-1:0] w_sat;

    // Q16.16 unity on tap 0 when INIT_UNITY, otherwise all zero.
    function automatic logic signed [COEF_W-1:0] init_coef(input int i);
        logic signed [COEF_W-1:0] v;
        v = '0;
        if (INIT_UNITY && i == 0) v[16] = 1'b1;
        return v;
    endfunction

    assign accept   = (state == IDLE) && sample_valid && !clear_coeffs;
    assign last_tap = (idx == IDX_W'(NTAPS - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_next  = state;
        update_done = 1'b0;
        if (clear_coeffs) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample_valid && !freeze) state_next = UPDATE;
                UPDATE:  if (last_tap) state_next = COMMIT;
                COMMIT: begin
                    state_next  = IDLE;
                    update_done = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Floor-rounded step, then saturate the COEF_W+1 sum back into COEF_W.
    always_comb begin
        prod       = PROD_W'(x_line[idx]) * PROD_W'(err_q);
        prod_shift = prod >>> MU_SHIFT;
        delta      = (COEF_W+1)'(prod_shift);
        sum        = (COEF_W+1)'(w_work[idx]) + delta;
        w_sat      = sum[COEF_W-1:0];
        if (sum[COEF_W] != sum[COEF_W-1])
            w_sat = sum[COEF_W] ? {1'b1, {(COEF_W-1){1'b0}}} : {1'b0, {(COEF_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the coefficient and delay arrays are flop-based and reset explicitly,
            // so coeffs_out carries the init set straight out of reset.
            for (int i = 0; i < NTAPS; i++) begin
                x_line[i]   <= '0;
                w_work[i]   <= init_coef(i);
                w_shadow[i] <= init_coef(i);
            end
            err_q          <= '0;
            idx            <= '0;
            sample_dropped <= 1'b0;
        end else begin
            sample_dropped <= sample_valid && busy && !clear_coeffs;
            if (clear_coeffs) begin
                for (int i = 0; i < NTAPS; i++) begin
                    w_work[i]   <= init_coef(i);
                    w_shadow[i] <= init_coef(i);
                end
                idx <= '0;
            end else begin
                if (accept) begin
                    x_line[0] <= signal_in;
                    for (int i = 1; i < NTAPS; i++) x_line[i] <= x_line[i-1];
                    err_q <= err_in;
                    idx   <= '0;
                end
                if (state == UPDATE) begin
                    w_work[idx] <= w_sat;
                    idx         <= idx + 1'b1;
                end
                if (state == COMMIT) begin
                    for (int i = 0; i < NTAPS; i++) w_shadow[i] <= w_work[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_pack
        assign coeffs_out[g*COEF_W +: COEF_W] = w_shadow[g];
    end

endmodule
